// File: rtl/act_requant_stage.sv
// Three-stage valid/ready requantizer: bias add, unsigned scale multiply,
// rounding arithmetic right shift and saturation to signed Q3.5.
module act_requant_stage #(
  parameter int ACC_W   = 24,
  parameter int SCALE_W = 8,
  parameter int SHIFT_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ACC_W-1:0]   in_acc,
  input  logic               in_last,
  input  logic [ACC_W-1:0]   cfg_bias,
  input  logic [SCALE_W-1:0] cfg_scale,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cnt_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_x,
  output logic               out_last,
  output logic               out_sat,
  output logic [CNT_W-1:0]   sat_count
);

  localparam int SUM_W  = ACC_W + 1;
  localparam int PROD_W = ACC_W + SCALE_W + 2;
  localparam int RND_W  = PROD_W + 1;

  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'(127);
  localparam logic signed [RND_W-1:0] SAT_MIN = -(RND_W'(128));

  logic en1, en2, en3;

  logic                     v1_reg;
  logic signed [SUM_W-1:0]  sum1_reg;
  logic [SCALE_W-1:0]       scale1_reg;
  logic [SHIFT_W-1:0]       shift1_reg;
  logic                     last1_reg;

  logic                     v2_reg;
  logic signed [PROD_W-1:0] prod2_reg;
  logic [SHIFT_W-1:0]       shift2_reg;
  logic                     last2_reg;

  logic                     v3_reg;
  logic [7:0]               x3_reg;
  logic                     last3_reg;
  logic                     sat3_reg;
  logic [CNT_W-1:0]         cnt_reg;

  // Ready ripples backward so a bubble anywhere lets the stages behind it advance.
  assign en3      = !v3_reg || out_ready;
  assign en2      = !v2_reg || en3;
  assign en1      = !v1_reg || en2;
  assign in_ready = en1;

  logic signed [SUM_W-1:0]  sum_next;
  logic signed [PROD_W-1:0] prod_next;
  logic signed [RND_W-1:0]  rnd_next;
  logic signed [RND_W-1:0]  rsum_next;
  logic signed [RND_W-1:0]  r_next;
  logic [7:0]               x_next;
  logic                     sat_next;

  assign sum_next  = $signed({in_acc[ACC_W-1], in_acc}) + $signed({cfg_bias[ACC_W-1], cfg_bias});
  assign prod_next = PROD_W'(sum1_reg) * PROD_W'($signed({1'b0, scale1_reg}));

  always_comb begin
    rnd_next = '0;
    if (shift2_reg != '0)
      rnd_next = RND_W'(1) << (shift2_reg - SHIFT_W'(1));
    // One extra bit of headroom keeps the rounding addend from overflowing.
    rsum_next = RND_W'(prod2_reg) + rnd_next;
    r_next    = rsum_next >>> shift2_reg;
    x_next    = r_next[7:0];
    sat_next  = 1'b0;
    if (r_next > SAT_MAX) begin
      x_next   = 8'h7F;
      sat_next = 1'b1;
    end else if (r_next < SAT_MIN) begin
      x_next   = 8'h80;
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_reg     <= 1'b0;
      sum1_reg   <= '0;
      scale1_reg <= '0;
      shift1_reg <= '0;
      last1_reg  <= 1'b0;
      v2_reg     <= 1'b0;
      prod2_reg  <= '0;
      shift2_reg <= '0;
      last2_reg  <= 1'b0;
      v3_reg     <= 1'b0;
      x3_reg     <= '0;
      last3_reg  <= 1'b0;
      sat3_reg   <= 1'b0;
    end else begin
      if (en1) begin
        v1_reg     <= in_valid;
        sum1_reg   <= sum_next;
        scale1_reg <= cfg_scale;
        shift1_reg <= cfg_shift;
        last1_reg  <= in_last;
      end
      if (en2) begin
        v2_reg     <= v1_reg;
        prod2_reg  <= prod_next;
        shift2_reg <= shift1_reg;
        last2_reg  <= last1_reg;
      end
      if (en3) begin
        v3_reg    <= v2_reg;
        x3_reg    <= x_next;
        last3_reg <= last2_reg;
        sat3_reg  <= sat_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_reg <= '0;
    else if (cnt_clr)
      cnt_reg <= '0;
    else if (v3_reg && out_ready && sat3_reg && (cnt_reg != '1))
      cnt_reg <= cnt_reg + CNT_W'(1);
  end

  assign out_valid = v3_reg;
  assign out_x     = x3_reg;
  assign out_last  = last3_reg;
  assign out_sat   = sat3_reg;
  assign sat_count = cnt_reg;

endmodule

// File: tb/tb_act_requant_stage.sv
// Directed bench for act_requant_stage: vector table plus backpressure,
// mid-stream config change and mid-stream reset sequences.
module tb_act_requant_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_acc;
  logic        in_last;
  logic [23:0] cfg_bias;
  logic [7:0]  cfg_scale;
  logic [4:0]  cfg_shift;
  logic        cnt_clr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_x;
  logic        out_last;
  logic        out_sat;
  logic [15:0] sat_count;

  int checks = 0;
  int errors = 0;

  act_requant_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .in_last   (in_last),
    .cfg_bias  (cfg_bias),
    .cfg_scale (cfg_scale),
    .cfg_shift (cfg_shift),
    .cnt_clr   (cnt_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_last  (out_last),
    .out_sat   (out_sat),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] acc;
    logic [23:0] bias;
    logic [7:0]  scale;
    logic [4:0]  shift;
    logic        last;
    logic        clr;
    logic [7:0]  exp_x;
    logic        exp_sat;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Single beat with out_ready held high: checks latency, data and counter.
  task automatic run_vec(input vec_t v, input int idx);
    int  n;
    bit  found;
    @(negedge clk);
    in_valid  = 1'b1;
    in_acc    = v.acc;
    in_last   = v.last;
    cfg_bias  = v.bias;
    cfg_scale = v.scale;
    cfg_shift = v.shift;
    out_ready = 1'b1;
    check("vec_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    n = 1;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1;
        break;
      end
      @(posedge clk);
      n++;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL vec_timeout idx=%0d actual=no out_valid required=out_valid within 10 cycles", idx);
    end else begin
      $display("vec %0d acc=%0h x=%0h sat=%0b last=%0b latency=%0d", idx, v.acc, out_x, out_sat, out_last, n);
      check("vec_latency", n, 3);
      check("vec_out_x", out_x, v.exp_x);
      check("vec_out_sat", out_sat, v.exp_sat);
      check("vec_out_last", out_last, v.last);
      cnt_clr = v.clr;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      @(negedge clk);
      check("vec_sat_count", sat_count, v.exp_cnt);
    end
  endtask

  initial begin
    int   sent;
    int   got;
    logic [7:0] bp_exp[6];
    vec_t v;

    //          acc          bias          scale shift last clr exp_x  sat  cnt
    vecs[0]  = '{24'd0,      24'd0,        8'd1, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
    vecs[1]  = '{24'd100,    24'd0,        8'd1, 5'd0, 1'b0, 1'b0, 8'h64, 1'b0, 16'd0};
    vecs[2]  = '{-24'd100,   24'd0,        8'd1, 5'd0, 1'b0, 1'b0, 8'h9C, 1'b0, 16'd0};
    vecs[3]  = '{24'd127,    24'd0,        8'd1, 5'd0, 1'b0, 1'b0, 8'h7F, 1'b0, 16'd0};
    vecs[4]  = '{-24'd128,   24'd0,        8'd1, 5'd0, 1'b1, 1'b0, 8'h80, 1'b0, 16'd0};
    vecs[5]  = '{24'd6,      24'd0,        8'd1, 5'd2, 1'b0, 1'b0, 8'h02, 1'b0, 16'd0};
    vecs[6]  = '{-24'd6,     24'd0,        8'd1, 5'd2, 1'b0, 1'b0, 8'hFF, 1'b0, 16'd0};
    vecs[7]  = '{24'd5,      24'd0,        8'd1, 5'd2, 1'b0, 1'b0, 8'h01, 1'b0, 16'd0};
    vecs[8]  = '{-24'd120,   24'd0,        8'd3, 5'd2, 1'b0, 1'b0, 8'hA6, 1'b0, 16'd0};
    vecs[9]  = '{24'd1000,   -24'd500,     8'd1, 5'd0, 1'b0, 1'b0, 8'h7F, 1'b1, 16'd1};
    vecs[10] = '{24'd0,      -24'd500,     8'd1, 5'd0, 1'b0, 1'b0, 8'h80, 1'b1, 16'd2};
    vecs[11] = '{24'd0,      -24'd500,     8'd1, 5'd0, 1'b0, 1'b1, 8'h80, 1'b1, 16'd0};
    vecs[12] = '{24'd1000,   -24'd500,     8'd1, 5'd0, 1'b0, 1'b0, 8'h7F, 1'b1, 16'd1};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_acc    = '0;
    in_last   = 1'b0;
    cfg_bias  = '0;
    cfg_scale = 8'd1;
    cfg_shift = '0;
    cnt_clr   = 1'b0;
    out_ready = 1'b1;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_x", out_x, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_out_sat", out_sat, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Backpressure with a scale change between beats 2 and 3.
    for (int i = 0; i < 6; i++) bp_exp[i] = 8'((i + 1) * 10 * ((i < 2) ? 1 : 2));
    sent = 0;
    got  = 0;
    cfg_bias  = '0;
    cfg_shift = '0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 6);
      if (sent < 6) begin
        in_valid  = 1'b1;
        in_acc    = 24'((sent + 1) * 10);
        cfg_scale = (sent < 2) ? 8'd1 : 8'd2;
        in_last   = (sent == 5);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      #1;
      if (cyc == 3) begin
        check("bp_accepted", sent, 3);
        check("bp_in_ready", in_ready, 0);
      end
      if (cyc >= 3 && cyc < 6) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_x", out_x, bp_exp[0]);
        check("bp_hold_last", out_last, 0);
      end
      if (out_valid && out_ready) begin
        $display("bp beat %0d x=%0h last=%0b", got + 1, out_x, out_last);
        check("bp_out_x", out_x, bp_exp[got]);
        check("bp_out_last", out_last, (got == 5) ? 1 : 0);
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bp_beats_out", got, 6);
    @(negedge clk);
    check("bp_drained", out_valid, 0);

    // Reset with three beats in flight; sat_count is 1 at this point.
    cfg_scale = 8'd1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_acc   = 24'(k + 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("pre_rst_sat_count", sat_count, 1);
    check("pre_rst_valid", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    $display("reset asserted mid-stream out_valid=%0b sat_count=%0d", out_valid, sat_count);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_x", out_x, 0);
    check("mid_rst_sat_count", sat_count, 0);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_no_stale", out_valid, 0);
    end
    v = '{24'd50, 24'd0, 8'd1, 5'd0, 1'b1, 1'b0, 8'h32, 1'b0, 16'd0};
    run_vec(v, 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
